// File: rtl/dino_pkg.sv
// dino_pkg: shared types and constants for the dinosaur game blocks.
//   dino_state_e  : jump controller states (GROUND, AIR)
//   HEIGHT_W      : height above ground, unsigned pixels
//   VEL_W         : vertical velocity, signed pixels/tick
//   Y_W           : sprite Y coordinate width
//   KEY_JUMP_P0/1 : default keypad jump codes for players 0 and 1
package dino_pkg;
  typedef enum logic {GROUND = 1'b0, AIR = 1'b1} dino_state_e;
  localparam int HEIGHT_W = 8;
  localparam int VEL_W = 8;
  localparam int Y_W = 9;
  localparam logic [4:0] KEY_JUMP_P0 = 5'h10;
  localparam logic [4:0] KEY_JUMP_P1 = 5'h12;
endpackage

// File: rtl/key_press_det.sv
// key_press_det: rising-edge detector on keypad ready, qualified by a key code.
//   clk       in  system clock
//   clrn      in  asynchronous active-low reset
//   run       in  1 = presses accepted, 0 = presses discarded
//   key_ready in  keypad ready level
//   key_code  in  keypad code, valid while key_ready = 1
//   press     out registered one-cycle pulse on a new press of CODE
module key_press_det
  import dino_pkg::*;
#(
  parameter logic [4:0] CODE = KEY_JUMP_P0
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       run,
  input  logic       key_ready,
  input  logic [4:0] key_code,
  output logic       press
);
  logic key_ready_d;
  // History tracks even while frozen so a key held across a freeze does not fire on resume.
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      key_ready_d <= 1'b0;
      press <= 1'b0;
    end else begin
      key_ready_d <= key_ready;
      press <= run & key_ready & ~key_ready_d & (key_code == CODE);
    end
endmodule

// File: rtl/dino_jump_ctrl.sv
// dino_jump_ctrl: per-player jump physics (velocity/gravity integration) with jump buffer and leg animation.
//   clk        in  system clock
//   clrn       in  asynchronous active-low reset
//   tick       in  one-cycle frame-step strobe
//   run        in  1 = game running, 0 = freeze all state
//   key_ready  in  keypad ready level
//   key_code   in  keypad code, valid while key_ready = 1
//   dino_y     out sprite top Y = GROUND_Y - height (registered)
//   airborne   out 1 while in AIR
//   leg        out leg animation phase
//   jump_start out one-cycle pulse on each launch
//   land_pulse out one-cycle pulse on touchdown
module dino_jump_ctrl
  import dino_pkg::*;
#(
  parameter logic [4:0]       JUMP_CODE = KEY_JUMP_P0,
  parameter logic [Y_W-1:0]   GROUND_Y  = 9'd146,
  parameter logic [VEL_W-1:0] V0        = 8'd12,
  parameter logic [VEL_W-1:0] GRAV      = 8'd1,
  parameter int               BUF_TICKS = 4,
  parameter int               LEG_DIV   = 8
) (
  input  logic           clk,
  input  logic           clrn,
  input  logic           tick,
  input  logic           run,
  input  logic           key_ready,
  input  logic [4:0]     key_code,
  output logic [Y_W-1:0] dino_y,
  output logic           airborne,
  output logic           leg,
  output logic           jump_start,
  output logic           land_pulse
);
  dino_state_e state, state_nxt;
  logic [HEIGHT_W-1:0] height, height_nxt;
  logic signed [VEL_W-1:0] vel, vel_nxt, vel_sat;
  logic signed [VEL_W:0] vel_dec;
  logic signed [9:0] sum;
  logic [7:0] buf_cnt, buf_nxt, leg_cnt, leg_cnt_nxt;
  logic leg_nxt, js_nxt, lp_nxt, press, p, t, land, buf_hit, leg_wrap;
  key_press_det #(.CODE(JUMP_CODE)) u_det (
    .clk(clk),
    .clrn(clrn),
    .run(run),
    .key_ready(key_ready),
    .key_code(key_code),
    .press(press)
  );
  // Freezing is done by masking both events; with neither active every register holds.
  assign p = press & run;
  assign t = tick & run;
  assign sum = $signed({2'b00, height}) + $signed({{2{vel[VEL_W-1]}}, vel});
  assign vel_dec = $signed({vel[VEL_W-1], vel}) - $signed({1'b0, GRAV});
  assign vel_sat = (vel_dec < -9'sd128) ? 8'sh80 : vel_dec[VEL_W-1:0];
  assign land = t & (sum <= 10'sd0);
  // A press arriving on the touchdown tick itself counts as buffered.
  assign buf_hit = (buf_cnt != 8'd0) | (p & (BUF_TICKS > 0));
  assign leg_wrap = leg_cnt == 8'(LEG_DIV - 1);
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      state <= GROUND;
      height <= '0;
      vel <= '0;
      buf_cnt <= '0;
      leg_cnt <= '0;
      leg <= 1'b0;
      jump_start <= 1'b0;
      land_pulse <= 1'b0;
      dino_y <= GROUND_Y;
    end else begin
      state <= state_nxt;
      height <= height_nxt;
      vel <= vel_nxt;
      buf_cnt <= buf_nxt;
      leg_cnt <= leg_cnt_nxt;
      leg <= leg_nxt;
      jump_start <= js_nxt;
      land_pulse <= lp_nxt;
      dino_y <= GROUND_Y - {1'b0, height_nxt};
    end
  always_comb begin
    state_nxt = state;
    height_nxt = height;
    vel_nxt = vel;
    buf_nxt = buf_cnt;
    leg_cnt_nxt = leg_cnt;
    leg_nxt = leg;
    js_nxt = 1'b0;
    lp_nxt = 1'b0;
    if (state == GROUND) begin
      // A tick coinciding with the press is swallowed by the launch.
      if (p) begin
        state_nxt = AIR;
        height_nxt = '0;
        vel_nxt = $signed(V0);
        buf_nxt = '0;
        js_nxt = 1'b1;
      end else if (t) begin
        leg_cnt_nxt = leg_wrap ? 8'd0 : leg_cnt + 8'd1;
        leg_nxt = leg ^ leg_wrap;
      end
    end else begin
      if (land) begin
        height_nxt = '0;
        leg_cnt_nxt = '0;
        buf_nxt = '0;
        lp_nxt = 1'b1;
        js_nxt = buf_hit;
        vel_nxt = buf_hit ? $signed(V0) : vel;
        state_nxt = buf_hit ? AIR : GROUND;
      end else if (t) begin
        height_nxt = (sum > 10'sd255) ? '1 : sum[HEIGHT_W-1:0];
        vel_nxt = vel_sat;
        buf_nxt = (buf_cnt != 8'd0) ? buf_cnt - 8'd1 : 8'd0;
      end
      // Loading the buffer overrides the same-tick decrement.
      if (p && BUF_TICKS > 0 && !land) buf_nxt = 8'(BUF_TICKS);
    end
  end
  always_comb airborne = (state == AIR);
endmodule

// File: tb/tb_dino_jump_ctrl.sv
// tb_dino_jump_ctrl: directed vectors into a scoreboard queue; an independent monitor pops and compares.
module tb_dino_jump_ctrl;
  logic clk = 1'b0, clrn = 1'b0, tick = 1'b0, run = 1'b1, key_ready = 1'b0;
  logic [4:0] key_code = 5'h0;
  logic [8:0] dino_y;
  logic airborne, leg, jump_start, land_pulse;
  typedef struct {
    logic [12:0] v;
    string nm;
  } exp_t;
  exp_t q[$];
  int n_vec = 0, n_err = 0;
  logic [8:0] traj [9] = '{9'd142, 9'd139, 9'd137, 9'd136, 9'd136, 9'd137, 9'd139, 9'd142, 9'd146};

  dino_jump_ctrl #(
    .JUMP_CODE(5'h10),
    .GROUND_Y(9'd146),
    .V0(8'd4),
    .GRAV(8'd1),
    .BUF_TICKS(4),
    .LEG_DIV(8)
  ) dut (
    .clk(clk),
    .clrn(clrn),
    .tick(tick),
    .run(run),
    .key_ready(key_ready),
    .key_code(key_code),
    .dino_y(dino_y),
    .airborne(airborne),
    .leg(leg),
    .jump_start(jump_start),
    .land_pulse(land_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, %0d vectors pending", q.size());
    $fatal(1, "timeout");
  end

  // Monitor: outputs of each clock are sampled 2 time units after the edge.
  initial begin
    exp_t e;
    logic [12:0] got;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        got = {dino_y, airborne, leg, jump_start, land_pulse};
        n_vec++;
        if (got !== e.v) begin
          n_err++;
          $display("FAIL %s: got y=%0d air=%b leg=%b js=%b lp=%b, expected y=%0d air=%b leg=%b js=%b lp=%b",
                   e.nm, got[12:4], got[3], got[2], got[1], got[0],
                   e.v[12:4], e.v[3], e.v[2], e.v[1], e.v[0]);
        end
      end
    end
  end

  task automatic cyc(input logic t, input logic kr, input logic [4:0] kc, input logic r, input logic rn,
                     input logic [8:0] y, input logic a, input logic l, input logic js, input logic lp,
                     input string nm);
    tick = t;
    key_ready = kr;
    key_code = kc;
    run = r;
    clrn = rn;
    q.push_back('{{y, a, l, js, lp}, nm});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press_launch(input logic l, input string nm);
    cyc(0, 1, 5'h10, 1, 1, 9'd146, 0, l, 0, 0, nm);
    cyc(0, 0, 5'h10, 1, 1, 9'd146, 1, l, 1, 0, nm);
  endtask

  task automatic reset_pulse(input string nm);
    cyc(0, 0, 5'h10, 1, 0, 9'd146, 0, 0, 0, 0, nm);
    cyc(0, 0, 5'h10, 1, 1, 9'd146, 0, 0, 0, 0, nm);
  endtask

  initial begin
    @(negedge clk);
    for (int i = 0; i < 6; i++) cyc(i % 2 == 1, i % 2 == 1, 5'h10, 1, 0, 9'd146, 0, 0, 0, 0, "reset_hold");
    for (int i = 0; i < 3; i++) cyc(0, 0, 5'h10, 1, 1, 9'd146, 0, 0, 0, 0, "reset_release");
    press_launch(0, "single_launch");
    for (int k = 1; k <= 9; k++) cyc(1, 0, 5'h10, 1, 1, traj[k-1], k < 9, 0, 0, k == 9, "single_jump");
    cyc(0, 0, 5'h10, 1, 1, 9'd146, 0, 0, 0, 0, "single_landed");
    for (int i = 0; i < 4; i++) cyc(0, i % 2 == 0, 5'h12, 1, 1, 9'd146, 0, 0, 0, 0, "wrong_code");
    for (int i = 0; i < 2; i++) cyc(0, 0, 5'h12, 1, 1, 9'd146, 0, 0, 0, 0, "wrong_code_idle");
    cyc(0, 1, 5'h10, 1, 1, 9'd146, 0, 0, 0, 0, "held_launch");
    cyc(0, 1, 5'h10, 1, 1, 9'd146, 1, 0, 1, 0, "held_launch");
    for (int k = 1; k <= 20; k++)
      cyc(1, 1, 5'h10, 1, 1, k <= 9 ? traj[k-1] : 9'd146, k < 9, k >= 17, 0, k == 9, "held_key");
    for (int i = 0; i < 2; i++) cyc(0, 0, 5'h10, 1, 1, 9'd146, 0, 1, 0, 0, "held_release");
    reset_pulse("reset_pulse");
    press_launch(0, "buf_launch");
    for (int k = 1; k <= 9; k++) cyc(1, k == 5, 5'h10, 1, 1, traj[k-1], 1, 0, k == 9, k == 9, "buf_rejump");
    for (int k = 1; k <= 9; k++) cyc(1, 0, 5'h10, 1, 1, traj[k-1], k < 9, 0, 0, k == 9, "buf_second_jump");
    press_launch(0, "expire_launch");
    for (int k = 1; k <= 9; k++) cyc(1, k == 2, 5'h10, 1, 1, traj[k-1], k < 9, 0, 0, k == 9, "buf_expired");
    cyc(0, 0, 5'h10, 1, 1, 9'd146, 0, 0, 0, 0, "expired_ground");
    press_launch(0, "freeze_launch");
    for (int k = 1; k <= 4; k++) cyc(1, 0, 5'h10, 1, 1, traj[k-1], 1, 0, 0, 0, "freeze_pre");
    for (int i = 0; i < 10; i++) cyc(1, i % 2 == 1, 5'h10, 0, 1, 9'd136, 1, 0, 0, 0, "freeze_hold");
    for (int k = 5; k <= 9; k++) cyc(1, 0, 5'h10, 1, 1, traj[k-1], k < 9, 0, 0, k == 9, "freeze_resume");
    reset_pulse("reset_before_leg");
    for (int i = 1; i <= 24; i++) cyc(1, 0, 5'h10, 1, 1, 9'd146, 0, ((i / 8) % 2) == 1, 0, 0, "leg_ground");
    press_launch(1, "leg_launch");
    for (int k = 1; k <= 3; k++) cyc(1, 0, 5'h10, 1, 1, traj[k-1], 1, 1, 0, 0, "leg_hold_air");
    cyc(0, 0, 5'h10, 1, 0, 9'd146, 0, 0, 0, 0, "midair_reset");
    for (int i = 0; i < 2; i++) cyc(0, 0, 5'h10, 1, 1, 9'd146, 0, 0, 0, 0, "after_reset");
    cyc(1, 0, 5'h10, 1, 1, 9'd146, 0, 0, 0, 0, "after_reset_tick");
    tick = 0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d vectors never compared, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
